// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_ctrl_if : stall/redirect/trap bundle between pipeline and pipe_ctrl |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface pipe_ctrl_if #(
  parameter int REG_BUS_WIDTH = 32
);
  logic                     stallreq_if_i;
  logic                     stallreq_id_i;
  logic                     stallreq_ex_i;
  logic                     stallreq_mem_i;
  logic                     jump_req_i;
  logic [REG_BUS_WIDTH-1:0] jump_pc_i;
  logic                     trap_req_i;
  logic [REG_BUS_WIDTH-1:0] trap_pc_i;
  logic [5:0]               stall_o;
  logic [3:0]               flush_o;
  logic                     pc_we_o;
  logic [REG_BUS_WIDTH-1:0] pc_new_o;
  logic                     trap_ack_o;
  logic                     stall_timeout_o;

  // Pipeline side: raises requests, obeys stall/flush/redirect.
  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output jump_req_i, jump_pc_i, trap_req_i, trap_pc_i,
    input  stall_o, flush_o, pc_we_o, pc_new_o, trap_ack_o, stall_timeout_o
  );

  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  jump_req_i, jump_pc_i, trap_req_i, trap_pc_i,
    output stall_o, flush_o, pc_we_o, pc_new_o, trap_ack_o, stall_timeout_o
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_ctrl : pipeline stall/flush arbiter, trap sequencer, stall watchdog |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pipe_ctrl #(
  parameter int REG_BUS_WIDTH = 32
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  pipe_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [7:0] WD_MAX      = 8'hFF;
  localparam logic [5:0] DRAIN_STALL = 6'b001111;

  logic [1:0]               state_q, state_d;
  logic [REG_BUS_WIDTH-1:0] trap_pc_q, trap_pc_d;
  logic                     drop_q, drop_d;
  logic [7:0]               wd_cnt_q, wd_cnt_d;
  logic                     timeout_q, timeout_d;

  logic [5:0]               base_stall;
  logic [5:0]               stall_c;
  logic [3:0]               flush_c;
  logic                     pc_we_c;
  logic [REG_BUS_WIDTH-1:0] pc_new_c;
  logic                     ack_c;
  logic                     redirect_c;

  // The deepest requesting stage freezes itself and everything upstream.
  always_comb begin
    base_stall = 6'b000000;
    if (bus.stallreq_mem_i) begin
      base_stall = 6'b011111;
    end else if (bus.stallreq_ex_i) begin
      base_stall = 6'b001111;
    end else if (bus.stallreq_id_i) begin
      base_stall = 6'b000111;
    end else if (bus.stallreq_if_i) begin
      base_stall = 6'b000011;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      trap_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      trap_pc_q <= trap_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    trap_pc_d = trap_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.trap_req_i) begin
          state_d   = ST_DRAIN;
          trap_pc_d = bus.trap_pc_i;
        end
      end
      ST_DRAIN: begin
        if (!bus.stallreq_mem_i) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_c    = base_stall;
    flush_c    = 4'b0000;
    pc_we_c    = 1'b0;
    pc_new_c   = '0;
    ack_c      = 1'b0;
    redirect_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A same-cycle trap wins; the jump source keeps its request held.
        if (!bus.trap_req_i && bus.jump_req_i && !base_stall[3]) begin
          pc_we_c      = 1'b1;
          pc_new_c     = bus.jump_pc_i;
          flush_c[1:0] = 2'b11;
          redirect_c   = 1'b1;
        end
      end
      ST_DRAIN: stall_c = base_stall | DRAIN_STALL;
      ST_FLUSH: begin
        stall_c    = 6'b000000;
        flush_c    = 4'b1111;
        pc_we_c    = 1'b1;
        pc_new_c   = trap_pc_q;
        ack_c      = 1'b1;
        redirect_c = 1'b1;
      end
      default: ;
    endcase

    // A fetch in flight at redirect time returns a stale instruction; kill it on arrival.
    drop_d = drop_q;
    if (drop_q && !bus.stallreq_if_i) begin
      flush_c[0] = 1'b1;
      drop_d     = 1'b0;
    end
    if (redirect_c && bus.stallreq_if_i) begin
      drop_d = 1'b1;
    end
  end

  always_comb begin
    if (stall_c == 6'b000000) begin
      wd_cnt_d = 8'h00;
    end else if (wd_cnt_q == WD_MAX) begin
      wd_cnt_d = WD_MAX;
    end else begin
      wd_cnt_d = wd_cnt_q + 8'h01;
    end
    timeout_d = timeout_q | (wd_cnt_d == WD_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q    <= 1'b0;
      wd_cnt_q  <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      drop_q    <= drop_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Combinational outputs are masked so reset silences them independent of inputs.
  assign bus.stall_o         = rst_n ? stall_c  : 6'b000000;
  assign bus.flush_o         = rst_n ? flush_c  : 4'b0000;
  assign bus.pc_we_o         = rst_n & pc_we_c;
  assign bus.pc_new_o        = rst_n ? pc_new_c : '0;
  assign bus.trap_ack_o      = rst_n & ack_c;
  assign bus.stall_timeout_o = rst_n & timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_ctrl : scoreboard bench for pipe_ctrl against a behavioural model|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_pipe_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.REG_BUS_WIDTH(W)) bus ();
  pipe_ctrl #(.REG_BUS_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [5:0]   stall;
    logic [3:0]   flush;
    logic         pc_we;
    logic [W-1:0] pc_new;
    logic         ack;
    logic         timeout;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state
  bit           m_trap_pend = 0;
  bit           m_flush_now = 0;
  logic [W-1:0] m_vec = '0;
  bit           m_drop = 0;
  int           m_cnt = 0;
  bit           m_to = 0;

  // Trap source: holds its request until it sees an acknowledge.
  bit           trap_hold = 0;
  logic [W-1:0] trap_hold_pc = '0;

  function automatic logic [5:0] stall_vec(bit sif, bit sid, bit sex, bit smem);
    int top;
    top = 0;
    if (sif)  top = 2;
    if (sid)  top = 3;
    if (sex)  top = 4;
    if (smem) top = 5;
    return 6'((1 << top) - 1);
  endfunction

  task automatic step(input bit rstn, input bit sif, input bit sid, input bit sex,
                      input bit smem, input bit jreq, input logic [W-1:0] jpc);
    exp_t e;
    bit   redirect;
    @(posedge clk);
    #1;
    rst_n              = rstn;
    bus.stallreq_if_i  = sif;
    bus.stallreq_id_i  = sid;
    bus.stallreq_ex_i  = sex;
    bus.stallreq_mem_i = smem;
    bus.jump_req_i     = jreq;
    bus.jump_pc_i      = jpc;
    bus.trap_req_i     = trap_hold;
    bus.trap_pc_i      = trap_hold_pc;
    e = '{stall: '0, flush: '0, pc_we: 1'b0, pc_new: '0, ack: 1'b0, timeout: 1'b0};
    redirect = 0;
    if (!rstn) begin
      m_trap_pend = 0; m_flush_now = 0; m_vec = '0; m_drop = 0; m_cnt = 0; m_to = 0;
    end else begin
      e.stall   = stall_vec(sif, sid, sex, smem);
      e.timeout = m_to;
      if (m_flush_now) begin
        e.stall = '0; e.flush = 4'hF; e.pc_we = 1; e.pc_new = m_vec; e.ack = 1;
        redirect = 1;
      end else if (m_trap_pend) begin
        e.stall = e.stall | 6'b001111;
      end else if (!trap_hold && jreq && !e.stall[3]) begin
        e.pc_we = 1; e.pc_new = jpc; e.flush = 4'b0011;
        redirect = 1;
      end
      if (m_drop && !sif) begin
        e.flush[0] = 1'b1;
        m_drop = 0;
      end
      if (redirect && sif) m_drop = 1;
      if (e.stall != 0) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      else              m_cnt = 0;
      if (m_cnt == 255) m_to = 1;
      if (m_flush_now) begin
        m_flush_now = 0;
      end else if (m_trap_pend) begin
        if (!smem) begin m_trap_pend = 0; m_flush_now = 1; end
      end else if (trap_hold) begin
        m_trap_pend = 1;
        m_vec = trap_hold_pc;
      end
    end
    exp_q.push_back(e);
    if (e.ack) trap_hold = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall_o",         64'(bus.stall_o),         64'(e.stall));
      chk("flush_o",         64'(bus.flush_o),         64'(e.flush));
      chk("pc_we_o",         64'(bus.pc_we_o),         64'(e.pc_we));
      chk("pc_new_o",        64'(bus.pc_new_o),        64'(e.pc_new));
      chk("trap_ack_o",      64'(bus.trap_ack_o),      64'(e.ack));
      chk("stall_timeout_o", 64'(bus.stall_timeout_o), 64'(e.timeout));
    end
  end

  initial begin
    bus.stallreq_if_i = 0; bus.stallreq_id_i = 0; bus.stallreq_ex_i = 0;
    bus.stallreq_mem_i = 0; bus.jump_req_i = 0; bus.jump_pc_i = '0;
    bus.trap_req_i = 0; bus.trap_pc_i = '0;

    // Reset with busy inputs: every output must stay low.
    trap_hold = 1; trap_hold_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 1, 32'h1234_5678);
    trap_hold = 0;
    idle(2);

    // Stall priority
    step(1, 0, 1, 0, 0, 0, '0);
    step(1, 0, 1, 0, 1, 0, '0);
    step(1, 0, 0, 0, 0, 0, '0);
    step(1, 1, 0, 1, 0, 0, '0);
    idle(1);

    // Plain jump
    step(1, 0, 0, 0, 0, 1, 32'h0000_0100);
    idle(1);

    // Jump while a fetch is outstanding, fetch completes three cycles later
    step(1, 1, 0, 0, 0, 1, 32'h0000_0200);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, '0);
    idle(2);

    // Jump blocked by ex stall
    step(1, 0, 0, 1, 0, 1, 32'h0000_0300);
    idle(1);

    // Trap with data bus busy four cycles, plus an ignored jump in DRAIN
    trap_hold = 1; trap_hold_pc = 32'h0000_0800;
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, i < 4, i == 2, 32'h0000_0900);
    idle(1);

    // Trap at minimum latency while a fetch is in flight
    trap_hold = 1; trap_hold_pc = 32'h0000_0C00;
    for (int i = 0; i < 4; i++) step(1, i < 2, 0, 0, 0, 0, '0);
    idle(1);

    // Watchdog saturation and stickiness
    for (int i = 0; i < 300; i++) step(1, 0, 0, 1, 0, 0, '0);
    idle(4);
    step(0, 0, 0, 0, 0, 0, '0);
    idle(2);

    // Reset in the middle of DRAIN with the trap request still held
    trap_hold = 1; trap_hold_pc = 32'h0000_0A00;
    step(1, 0, 0, 0, 1, 0, '0);
    step(1, 0, 0, 0, 1, 0, '0);
    step(0, 0, 0, 0, 1, 0, '0);
    step(0, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, '0);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit rstn;
      rstn = ($urandom_range(0, 299) != 0);
      if (!trap_hold && ($urandom_range(0, 24) == 0)) begin
        trap_hold = 1;
        trap_hold_pc = $urandom;
      end
      step(rstn, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), W'($urandom));
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_BUS_WIDTH, default 32, width of PC/address values.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port stallreq_if_i  input  1  fetch bus busy (instruction fetch in flight).
REQ-005 SHALL have port stallreq_id_i  input  1  decode hazard (load-use).
REQ-006 SHALL have port stallreq_ex_i  input  1  execute multi-cycle op busy.
REQ-007 SHALL have port stallreq_mem_i  input  1  data bus busy.
REQ-008 SHALL have port jump_req_i / jump_pc_i  input  1 / REG_BUS_WIDTH  EX-stage branch/jump redirect and target.
REQ-009 SHALL have port trap_req_i / trap_pc_i  input  1 / REG_BUS_WIDTH  trap request (level, held until ack) and vector.
REQ-010 SHALL have port stall_o  output  6  per-stage hold: [0]pc [1]if [2]id [3]ex [4]mem [5]wb.
REQ-011 SHALL have port flush_o  output  4  register clear: [0]if/id [1]id/ex [2]ex/mem [3]mem/wb.
REQ-012 SHALL have port pc_we_o / pc_new_o  output  1 / REG_BUS_WIDTH  PC overwrite strobe and value.
REQ-013 SHALL have port trap_ack_o  output  1  one-cycle trap acceptance.
REQ-014 SHALL have port stall_timeout_o  output  1  sticky stall watchdog flag.

Function
REQ-015 stall_o SHALL be combinational, highest requesting stage wins: mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; if -> 6'b000011; none -> 6'b000000.
REQ-016 Trap FSM states SHALL be IDLE, DRAIN, FLUSH; DRAIN and FLUSH are entered only via a trap request.
REQ-017 IDLE: trap_req_i=1 SHALL latch trap_pc_i and move to DRAIN next cycle; trap has priority over a same-cycle jump_req_i.
REQ-018 DRAIN: stall_o SHALL be forced to at least 6'b001111 (OR with REQ-015 vector); move to FLUSH on the first cycle stallreq_mem_i=0.
REQ-019 FLUSH (exactly 1 cycle): flush_o=4'b1111, pc_we_o=1, pc_new_o=latched trap PC, trap_ack_o=1, stall_o=0; return to IDLE.
REQ-020 Minimum trap latency: request in cycle N with mem idle -> ack in cycle N+2.
REQ-021 Jump: in IDLE with jump_req_i=1 and stall_o[3]=0, SHALL assert pc_we_o=1, pc_new_o=jump_pc_i, flush_o[1:0]=2'b11 same cycle; with stall_o[3]=1 no action (source holds request).
REQ-022 jump_req_i SHALL be ignored in DRAIN and FLUSH.
REQ-023 Drop-pending flag: set when a redirect (jump or FLUSH) occurs while stallreq_if_i=1; while set, on the first cycle stallreq_if_i=0, flush_o[0] SHALL assert and flag clears.
REQ-024 A redirect while drop-pending already set SHALL keep it set (single in-flight fetch).
REQ-025 Otherwise flush_o=0, pc_we_o=0, pc_new_o=0, trap_ack_o=0.
REQ-026 Watchdog: 8-bit counter increments each cycle stall_o!=0, clears when stall_o=0, saturates at 255; reaching 255 sets stall_timeout_o, cleared only by reset.

Reset
REQ-027 rst_n low SHALL asynchronously force FSM=IDLE, drop-pending=0, latched trap PC=0, counter=0, stall_timeout_o=0.
REQ-028 While rst_n low, all outputs SHALL be 0 regardless of inputs.
REQ-029 Reset mid-DRAIN SHALL abandon the trap without ack; a still-held trap_req_i restarts from IDLE after release.

Verification
REQ-030 stallreq_id_i=1 alone -> stall_o=6'b000111; add stallreq_mem_i=1 -> 6'b011111; all low -> 0.
REQ-031 jump_req_i=1, jump_pc_i=32'h0000_0100, no stalls -> same cycle pc_we_o=1, pc_new_o=32'h100, flush_o=4'b0011.
REQ-032 jump with stallreq_if_i=1 for 3 more cycles -> flush_o=4'b0001 in cycle stallreq_if_i falls, then 0.
REQ-033 trap_req_i=1, trap_pc_i=32'h0000_0800, stallreq_mem_i=1 for 4 cycles -> stall_o>=6'b001111 during wait, then FLUSH: flush_o=4'b1111, pc_new_o=32'h800, trap_ack_o=1 for one cycle.
REQ-034 stallreq_ex_i held 300 cycles -> stall_timeout_o=1 after 255 stalled cycles, stays 1 after stall drops until rst_n.
REQ-035 rst_n low during DRAIN -> all outputs 0 immediately, no trap_ack_o; after release with trap_req_i held -> ack 2 cycles later.
